// File: rtl/jtframe_dial_sched_if.sv
// Player-side bus of the dial scheduler: displacement strobes in, quadrature dials and status out.
interface jtframe_dial_sched_if;
    // st1/st2 are one-cycle valids for dx1/dx2 with no ready: a strobe is accepted in every state.
    logic       st1;
    logic       st2;
    logic [7:0] dx1;
    logic [7:0] dx2;
    logic [1:0] dial_x;
    logic [1:0] dial_y;
    logic       busy;
    logic [1:0] state;

    modport master (output st1, st2, dx1, dx2, input dial_x, dial_y, busy, state);
    modport slave  (input st1, st2, dx1, dx2, output dial_x, dial_y, busy, state);
endinterface

// File: rtl/jtframe_dial_sched.sv
// Dial step scheduler: two saturating displacement accumulators drained one quadrature
// step per scheduling tick, round-robin between players, paced by horizontal blanking.
module jtframe_dial_sched #(
    parameter int ACCW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 LHBL,
    input  logic [1:0]           sensty,
    jtframe_dial_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, STEP = 2'd2} state_t;

    // Sum width covers acc + sext(dx) +/- 1 without overflow for any ACCW >= 4
    localparam int SW = ((ACCW > 8) ? ACCW : 8) + 2;
    localparam logic signed [SW-1:0] ONE  = SW'(1);
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (ACCW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    state_t          state_q, state_d;
    logic            lhbl_l;
    logic [2:0]      div;
    logic [2:0]      mask;
    logic            line, tick;
    logic [ACCW-1:0] acc1, acc2;
    logic            p1, p2;
    logic            rr, sel_q, sel_d;
    logic            take1, take2;
    logic [1:0]      dial_x, dial_y;

    function automatic logic [ACCW-1:0] next_acc(input logic [ACCW-1:0] acc, input logic st,
                                                 input logic [7:0] dx, input logic take);
        logic signed [SW-1:0] s;
        s = $signed({{(SW-ACCW){acc[ACCW-1]}}, acc});
        if (st)
            s = s + $signed({{(SW-8){dx[7]}}, dx});
        // The step term follows the sign of the pre-update accumulator
        if (take)
            s = acc[ACCW-1] ? s + ONE : s - ONE;
        if (s > MAXV)
            next_acc = MAXV[ACCW-1:0];
        else if (s < MINV)
            next_acc = MINV[ACCW-1:0];
        else
            next_acc = s[ACCW-1:0];
    endfunction

    function automatic logic [1:0] quad(input logic [1:0] q, input logic fwd);
        case (q)
            2'b00:   quad = fwd ? 2'b01 : 2'b10;
            2'b01:   quad = fwd ? 2'b11 : 2'b00;
            2'b11:   quad = fwd ? 2'b10 : 2'b01;
            default: quad = fwd ? 2'b00 : 2'b11;
        endcase
    endfunction

    always_comb begin
        case (sensty)
            2'd0:    mask = 3'd0;
            2'd1:    mask = 3'd1;
            2'd2:    mask = 3'd3;
            default: mask = 3'd7;
        endcase
    end

    assign line = LHBL & ~lhbl_l;
    assign tick = line & ((div & mask) == 3'd0);
    assign p1   = acc1 != '0;
    assign p2   = acc2 != '0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        take1   = 1'b0;
        take2   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick)
                    state_d = GRANT;
            end
            GRANT: begin
                if (p1 || p2) begin
                    state_d = STEP;
                    sel_d   = (p1 && p2) ? rr : p2;
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                state_d = IDLE;
                take1   = !sel_q && p1;
                take2   = sel_q && p2;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lhbl_l  <= 1'b1;
            div     <= 3'd0;
            acc1    <= '0;
            acc2    <= '0;
            rr      <= 1'b0;
            sel_q   <= 1'b0;
            dial_x  <= 2'b00;
            dial_y  <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            lhbl_l  <= LHBL;
            if (line)
                div <= div + 3'd1;
            acc1 <= next_acc(acc1, bus.st1, bus.dx1, take1);
            acc2 <= next_acc(acc2, bus.st2, bus.dx2, take2);
            if (take1)
                dial_x <= quad(dial_x, ~acc1[ACCW-1]);
            if (take2)
                dial_y <= quad(dial_y, ~acc2[ACCW-1]);
            if (take1 || take2)
                rr <= ~sel_q;
        end
    end

    assign bus.dial_x = dial_x;
    assign bus.dial_y = dial_y;
    assign bus.busy   = state_q != IDLE;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_jtframe_dial_sched.sv
// Directed bench for jtframe_dial_sched: reset, single/dual player stepping, divisor,
// saturation and strobe/step collision, checked with immediate assertions.
module tb_jtframe_dial_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       LHBL = 1'b1;
    logic [1:0] sensty = 2'd0;
    int         n_chk = 0;
    int         n_fail = 0;

    jtframe_dial_sched_if bus();

    jtframe_dial_sched #(.ACCW(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .LHBL   (LHBL),
        .sensty (sensty),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Leaves the bench just before E0 (LHBL_l=0 registered, LHBL=1 driven)
    task automatic do_line();
        LHBL = 1'b0;
        cyc(1);
        LHBL = 1'b1;
    endtask

    task automatic strobe(input logic s1, input logic [7:0] d1, input logic s2, input logic [7:0] d2);
        bus.st1 = s1;
        bus.dx1 = d1;
        bus.st2 = s2;
        bus.dx2 = d2;
        cyc(1);
        bus.st1 = 1'b0;
        bus.st2 = 1'b0;
    endtask

    logic [1:0] exp_x[5] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [1:0] exp_xy[4][2] = '{'{2'b01, 2'b00}, '{2'b01, 2'b10}, '{2'b11, 2'b10}, '{2'b11, 2'b11}};
    logic [1:0] prev_x;
    int         changes;

    initial begin
        bus.st1 = 1'b0;
        bus.st2 = 1'b0;
        bus.dx1 = 8'd0;
        bus.dx2 = 8'd0;
        cyc(2);
        check("rst_dial_x", 32'(bus.dial_x), 32'd0);
        check("rst_dial_y", 32'(bus.dial_y), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Single player, +3 over 5 lines
        strobe(1'b1, 8'd3, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            do_line();
            cyc(1);
            check("single_busy_e0", 32'(bus.busy), 32'd1);
            cyc(1);
            check("single_busy_e1", 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
            check("single_hold_e1", 32'(bus.dial_x), (i == 0) ? 32'd0 : 32'(exp_x[i-1]));
            cyc(1);
            check("single_dial_x", 32'(bus.dial_x), 32'(exp_x[i]));
            check("single_dial_y", 32'(bus.dial_y), 32'd0);
            check("single_busy_e2", 32'(bus.busy), 32'd0);
        end

        // Asynchronous reset while in STEP
        strobe(1'b0, 8'd0, 1'b1, 8'd1);
        do_line();
        cyc(2);
        check("mid_state_step", 32'(bus.state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_dial_x", 32'(bus.dial_x), 32'd0);
        check("async_dial_y", 32'(bus.dial_y), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("async_acc2", 32'(dut.acc2), 32'd0);
        do_line();
        cyc(1);
        check("empty_busy_e0", 32'(bus.busy), 32'd1);
        cyc(1);
        check("empty_busy_e1", 32'(bus.busy), 32'd0);
        cyc(1);
        check("empty_dial_x", 32'(bus.dial_x), 32'd0);
        check("empty_dial_y", 32'(bus.dial_y), 32'd0);

        // Both players pending: round-robin starting with player 1
        do_reset();
        strobe(1'b1, 8'd2, 1'b1, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            do_line();
            cyc(3);
            check("rr_dial_x", 32'(bus.dial_x), 32'(exp_xy[i][0]));
            check("rr_dial_y", 32'(bus.dial_y), 32'(exp_xy[i][1]));
        end

        // Divisor of 8 lines
        do_reset();
        sensty = 2'd3;
        strobe(1'b1, 8'hFE, 1'b0, 8'd0);
        for (int i = 1; i <= 9; i++) begin
            do_line();
            cyc(1);
            check("div_busy_e0", 32'(bus.busy), (i == 1 || i == 9) ? 32'd1 : 32'd0);
            cyc(2);
            check("div_dial_x", 32'(bus.dial_x), (i < 9) ? 32'b10 : 32'b11);
        end
        sensty = 2'd0;

        // Saturation, both directions
        do_reset();
        strobe(1'b1, 8'h80, 1'b0, 8'd0);
        strobe(1'b1, 8'h80, 1'b0, 8'd0);
        check("sat_neg_acc1", 32'(dut.acc1), 32'h80);
        do_reset();
        strobe(1'b1, 8'd100, 1'b0, 8'd0);
        strobe(1'b1, 8'd100, 1'b0, 8'd0);
        check("sat_pos_acc1", 32'(dut.acc1), 32'd127);
        changes = 0;
        prev_x = bus.dial_x;
        for (int i = 0; i < 130; i++) begin
            do_line();
            cyc(3);
            if (bus.dial_x != prev_x)
                changes++;
            prev_x = bus.dial_x;
        end
        check("sat_steps", 32'(changes), 32'd127);
        check("sat_acc1_end", 32'(dut.acc1), 32'd0);
        check("sat_dial_x", 32'(bus.dial_x), 32'b10);

        // Strobe landing in the STEP cycle
        do_reset();
        strobe(1'b1, 8'd1, 1'b0, 8'd0);
        do_line();
        cyc(2);
        bus.st1 = 1'b1;
        bus.dx1 = 8'hFF;
        cyc(1);
        bus.st1 = 1'b0;
        check("coll_acc1", 32'(dut.acc1), 32'hFF);
        check("coll_dial_x", 32'(bus.dial_x), 32'b01);
        do_line();
        cyc(3);
        check("coll_back_dial_x", 32'(bus.dial_x), 32'b00);
        check("coll_acc1_end", 32'(dut.acc1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
